// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte image and writes it into
// instruction memory one 32-bit word at a time. The riscv core is held in
// reset until the whole image has been written.
//
// Image format: 16-bit word count N (low byte first), then N little-endian
// 32-bit words. With IMEM_LOADER_CHECKSUM_EN defined, one more byte follows.
// That byte must equal the XOR of all payload bytes, or the image is rejected.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   byte_valid/byte_data  incoming image byte
//   byte_ready            loader accepts a byte this cycle
//   imem_we/addr/wdata    one-cycle word write into instruction memory
//   core_rst              core reset, released when the image is loaded
//   done / err            sticky load-complete / image-rejected flags
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        PAYLOAD = 3'd2,
        WRITE   = 3'd3,
        CSUM    = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        LEN_LO  = 3'd0,
        LEN_HI  = 3'd1,
        PAYLOAD = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic        xfer;
    logic        len_ok;
    logic        last_word;
    logic        ready_nxt;
    logic [15:0] len_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_LO;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; byte_ready for the next cycle follows the next state
    always_comb begin
        state_nxt = state;
        ready_nxt = 1'b0;
        xfer      = byte_valid && byte_ready;
        len_word  = {byte_data, len[7:0]};
        len_ok    = (len_word != 16'd0) && (32'(len_word) <= MAX_WORDS);
        last_word = (word_cnt == (len - 16'd1));

        case (state)
            LEN_LO:  if (xfer) state_nxt = LEN_HI;
            LEN_HI:  if (xfer) state_nxt = len_ok ? PAYLOAD : ERROR;
            PAYLOAD: if (xfer && (byte_cnt == 2'd3)) state_nxt = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            WRITE:   state_nxt = last_word ? CSUM : PAYLOAD;
            CSUM:    if (xfer) state_nxt = (byte_data == csum) ? DONE : ERROR;
`else
            WRITE:   state_nxt = last_word ? DONE : PAYLOAD;
`endif
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = LEN_LO;
        endcase

        case (state_nxt)
            LEN_LO, LEN_HI, PAYLOAD: ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:                    ready_nxt = 1'b1;
`endif
            default:                 ready_nxt = 1'b0;
        endcase
    end

    // Registered outputs and payload datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            core_rst   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_buf   <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            byte_ready <= ready_nxt;
            imem_we    <= (state_nxt == WRITE);
            core_rst   <= (state_nxt != DONE);
            done       <= (state_nxt == DONE);
            err        <= (state_nxt == ERROR);

            if ((state == LEN_LO) && xfer) len[7:0]  <= byte_data;
            if ((state == LEN_HI) && xfer) len[15:8] <= byte_data;

            if ((state == PAYLOAD) && xfer) begin
                byte_cnt <= byte_cnt + 2'd1;
                // Bytes shift in from the top so byte k ends up at [8k+7:8k]
                word_buf <= {byte_data, word_buf[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ byte_data;
`endif
                if (byte_cnt == 2'd3) begin
                    imem_wdata <= {byte_data, word_buf};
                    imem_addr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                end
            end

            if (state == WRITE) word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Instance a uses the default parameters;
// instance b uses BASE_ADDR=0x1000, MAX_WORDS=4. sel chooses which instance
// receives the byte stream and whose outputs are observed.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bv  = 1'b0;
    logic [7:0]  bd  = 8'd0;
    logic        sel = 1'b0;
    logic        gap = 1'b0;

    logic        a_bv, a_br, a_we, a_cr, a_done, a_err;
    logic [31:0] a_addr, a_wdata;
    logic        b_bv, b_br, b_we, b_cr, b_done, b_err;
    logic [31:0] b_addr, b_wdata;

    logic        br, we, cr, done, err;
    logic [31:0] addr, wdata;

    int          total     = 0;
    int          bad       = 0;
    int          stall_cnt = 0;
    int          we_a      = 0;
    int          we_b      = 0;
    logic [7:0]  csum_m    = 8'd0;

    always #5 clk = ~clk;

    assign a_bv  = bv & ~sel;
    assign b_bv  = bv & sel;
    assign br    = sel ? b_br    : a_br;
    assign we    = sel ? b_we    : a_we;
    assign cr    = sel ? b_cr    : a_cr;
    assign done  = sel ? b_done  : a_done;
    assign err   = sel ? b_err   : a_err;
    assign addr  = sel ? b_addr  : a_addr;
    assign wdata = sel ? b_wdata : a_wdata;

    imem_loader u_dut_a (
        .clk(clk), .rst(rst), .byte_valid(a_bv), .byte_data(bd),
        .byte_ready(a_br), .imem_we(a_we), .imem_addr(a_addr),
        .imem_wdata(a_wdata), .core_rst(a_cr), .done(a_done), .err(a_err)
    );

    imem_loader #(.BASE_ADDR(32'h0000_1000), .MAX_WORDS(4)) u_dut_b (
        .clk(clk), .rst(rst), .byte_valid(b_bv), .byte_data(bd),
        .byte_ready(b_br), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .core_rst(b_cr), .done(b_done), .err(b_err)
    );

    // Count every write strobe of each instance
    always @(negedge clk) begin
        if (a_we) we_a++;
        if (b_we) we_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bv  = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        csum_m = 8'd0;
    endtask

    // Offer one byte from a negedge; return at the negedge after it transfers
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bv = 1'b1;
        bd = b;
        while (!br && n < 40) begin
            stall_cnt++;
            @(negedge clk);
            n++;
        end
        if (!br) begin
            check("byte_timeout", 32'd0, 32'd1);
            bv = 1'b0;
            return;
        end
        @(negedge clk);
        bv = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [31:0] w, input logic [31:0] exp_addr);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
            b      = w[8*k +: 8];
            csum_m = csum_m ^ b;
            send_byte(b);
        end
        check({tag, "_we"},   32'(we), 32'd1);
        check({tag, "_addr"}, addr,    exp_addr);
        check({tag, "_data"}, wdata,   w);
    endtask

    // Move from the last WRITE cycle into DONE
    task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_m);
`else
        @(negedge clk);
`endif
    endtask

    initial begin
        int snap;
        sel = 1'b0;
        gap = 1'b0;

        // Reset values
        do_reset();
        check("rst_ready", 32'(br),   32'd1);
        check("rst_we",    32'(we),   32'd0);
        check("rst_addr",  addr,      32'h0);
        check("rst_wdata", wdata,     32'h0);
        check("rst_crst",  32'(cr),   32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err),  32'd0);

        // Basic load, byte_valid held continuously
        stall_cnt = 0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word("w0", 32'h0000_0513, 32'h0);
        send_word("w1", 32'h0010_0093, 32'h4);
        check("stall_one_per_word", 32'(stall_cnt), 32'd1);
        check("crst_before_done",   32'(cr),        32'd1);
        check("done_before_end",    32'(done),      32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        // XOR of the eight payload bytes is 0x95
        check("csum_model", 32'(csum_m), 32'h95);
`endif
        finish_image();
        check("basic_done",  32'(done), 32'd1);
        check("basic_crst",  32'(cr),   32'd0);
        check("basic_err",   32'(err),  32'd0);
        check("basic_ready", 32'(br),   32'd0);
        check("basic_wecnt", 32'(we_a), 32'd2);

        // DONE absorbs further input
        bv = 1'b1;
        bd = 8'hff;
        repeat (4) @(negedge clk);
        bv = 1'b0;
        check("done_sticky", 32'(done), 32'd1);
        check("done_no_we",  32'(we_a), 32'd2);

        // Reset from DONE brings core_rst back
        do_reset();
        check("rst_from_done_crst", 32'(cr),   32'd1);
        check("rst_from_done_done", 32'(done), 32'd0);

        // N = 0 rejected
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_err",   32'(err),  32'd1);
        check("n0_crst",  32'(cr),   32'd1);
        check("n0_ready", 32'(br),   32'd0);
        check("n0_done",  32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("n0_no_we", 32'(we_a), 32'd2);

        // N = MAX_WORDS+1 rejected, N = MAX_WORDS accepted
        do_reset();
        send_byte(8'h01);
        send_byte(8'h04);
        check("n1025_err",  32'(err),  32'd1);
        check("n1025_crst", 32'(cr),   32'd1);
        do_reset();
        send_byte(8'h00);
        send_byte(8'h04);
        check("n1024_err",   32'(err), 32'd0);
        check("n1024_ready", 32'(br),  32'd1);
        check("n_bad_no_we", 32'(we_a), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum mismatch: payload XOR is 0x04, 0x05 sent
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        send_word("cs", 32'h0403_0201, 32'h0);
        send_byte(8'h05);
        check("csum_bad_err",  32'(err),  32'd1);
        check("csum_bad_crst", 32'(cr),   32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
`endif

        // Mid-load reset abandons the partial word
        do_reset();
        snap = we_a;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word("m0", 32'h1122_3344, 32'h0);
        send_byte(8'h55);
        send_byte(8'h66);
        do_reset();
        check("mid_no_partial_we", 32'(we_a), 32'(snap + 1));
        check("mid_addr_reset",    addr,      32'h0);
        send_byte(8'h01);
        send_byte(8'h00);
        send_word("m1", 32'hcafe_f00d, 32'h0);
        finish_image();
        check("mid_done",  32'(done), 32'd1);
        check("mid_wecnt", 32'(we_a), 32'(snap + 2));

        // Gapped input on the BASE_ADDR=0x1000 instance
        sel = 1'b1;
        gap = 1'b1;
        do_reset();
        check("b_rst_addr", addr, 32'h0000_1000);
        send_byte(8'h03);
        repeat (2) @(negedge clk);
        send_byte(8'h00);
        send_word("g0", 32'h0000_0513, 32'h0000_1000);
        send_word("g1", 32'h0010_0093, 32'h0000_1004);
        send_word("g2", 32'hdead_beef, 32'h0000_1008);
        repeat (2) @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_m);
`endif
        check("g_done",  32'(done), 32'd1);
        check("g_crst",  32'(cr),   32'd0);
        check("g_wecnt", 32'(we_b), 32'd3);

        // MAX_WORDS boundary on the small instance
        gap = 1'b0;
        do_reset();
        send_byte(8'h05);
        send_byte(8'h00);
        check("b_n5_err", 32'(err), 32'd1);
        do_reset();
        send_byte(8'h04);
        send_byte(8'h00);
        check("b_n4_err",   32'(err), 32'd0);
        check("b_n4_ready", 32'(br),  32'd1);
        check("a_untouched", 32'(we_a), 32'(snap + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
